// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the sequencer, its datapath and the bench.
// Opcodes, FSM states and ALU function codes.
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5,
        OP_JMP   = 4'd6,
        OP_JZ    = 4'd7
    } opcode_t;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOAD_A = 4'd3,
        ST_LOAD_B = 4'd4,
        ST_STORE  = 4'd5,
        ST_ADD    = 4'd6,
        ST_SUB    = 4'd7,
        ST_JUMP   = 4'd8,
        ST_HALT   = 4'd9,
        ST_FAULT  = 4'd10
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/control_sequencer_pc.sv
// Program counter: clear, load and increment, wrapping modulo 2^PC_W.
// Clear wins over load, load wins over increment.
module pc_counter
    import control_sequencer_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle sequencer: PC, instruction register and control FSM.
// Outputs are decoded from the state register and IR only.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int PC_W  = 7,
    parameter int RF_AW = 4,
    parameter int D_AW  = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic [PC_W-1:0]        I_Addr,
    output logic                   I_Req,
    input  logic                   I_Valid,
    input  logic [4+3*RF_AW-1:0]   I_Data,
    input  logic                   Alu_Zero,
    input  logic                   Resume,
    output logic [D_AW-1:0]        D_Addr,
    output logic                   D_Wr,
    output logic                   RF_s,
    output logic [RF_AW-1:0]       RF_Ra_Addr,
    output logic [RF_AW-1:0]       RF_Rb_Addr,
    output logic                   RF_W_en,
    output logic [RF_AW-1:0]       RF_W_Addr,
    output logic [2:0]             ALU_s0,
    output logic [3:0]             State,
    output logic [4+3*RF_AW-1:0]   IR_Out,
    output logic                   Halted,
    output logic                   Fault
);

    localparam int R    = RF_AW;
    localparam int IR_W = 4 + 3 * RF_AW;

    state_t          state;
    state_t          state_nx;
    logic [IR_W-1:0] ir;
    logic [3:0]      op;
    logic [R-1:0]    fa;
    logic [R-1:0]    fb;
    logic [R-1:0]    fw;
    logic [D_AW-1:0] ld_addr;
    logic [D_AW-1:0] st_addr;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc;
    logic            pc_clr;
    logic            pc_inc;
    logic            pc_load;

    assign op      = ir[IR_W-1 -: 4];
    assign fa      = ir[3*R-1 -: R];
    assign fb      = ir[2*R-1 -: R];
    assign fw      = ir[R-1:0];
    assign ld_addr = ir[R+D_AW-1 -: D_AW];
    assign st_addr = ir[D_AW-1:0];
    assign target  = ir[PC_W-1:0];

    assign pc_clr  = (state == ST_INIT);
    assign pc_inc  = (state == ST_FETCH) && I_Valid;
    assign pc_load = (state == ST_JUMP);

    pc_counter #(
        .PC_W(PC_W)
    ) u_pc (
        .clk     (Clock),
        .rst     (Reset),
        .clr     (pc_clr),
        .inc     (pc_inc),
        .load    (pc_load),
        .load_val(target),
        .pc      (pc)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ir <= '0;
        end else if (pc_inc) begin
            ir <= I_Data;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_INIT:   state_nx = ST_FETCH;
            ST_FETCH:  if (I_Valid) state_nx = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_NOOP:  state_nx = ST_FETCH;
                    OP_STORE: state_nx = ST_STORE;
                    OP_LOAD:  state_nx = ST_LOAD_A;
                    OP_ADD:   state_nx = ST_ADD;
                    OP_SUB:   state_nx = ST_SUB;
                    OP_HALT:  state_nx = ST_HALT;
                    OP_JMP:   state_nx = ST_JUMP;
                    OP_JZ:    state_nx = Alu_Zero ? ST_JUMP : ST_FETCH;
                    default:  state_nx = ST_FAULT;
                endcase
            end
            ST_LOAD_A: state_nx = ST_LOAD_B;
            ST_LOAD_B: state_nx = ST_FETCH;
            ST_STORE:  state_nx = ST_FETCH;
            ST_ADD:    state_nx = ST_FETCH;
            ST_SUB:    state_nx = ST_FETCH;
            ST_JUMP:   state_nx = ST_FETCH;
            ST_HALT:   if (Resume) state_nx = ST_FETCH;
            ST_FAULT:  state_nx = ST_FAULT;
            default:   state_nx = ST_FAULT;
        endcase
    end

    // Unused addresses and strobes read as zero in every state.
    always_comb begin
        I_Req      = 1'b0;
        D_Addr     = '0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_Ra_Addr = '0;
        RF_Rb_Addr = '0;
        RF_W_en    = 1'b0;
        RF_W_Addr  = '0;
        ALU_s0     = ALU_PASS;
        unique case (state)
            ST_FETCH: I_Req = 1'b1;
            ST_LOAD_A: begin
                D_Addr    = ld_addr;
                RF_s      = 1'b1;
                RF_W_Addr = fw;
            end
            ST_LOAD_B: begin
                D_Addr    = ld_addr;
                RF_s      = 1'b1;
                RF_W_Addr = fw;
                RF_W_en   = 1'b1;
            end
            ST_STORE: begin
                D_Addr     = st_addr;
                RF_Ra_Addr = fa;
                D_Wr       = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                RF_Ra_Addr = fa;
                RF_Rb_Addr = fb;
                RF_W_Addr  = fw;
                RF_W_en    = 1'b1;
                ALU_s0     = (state == ST_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end

    assign I_Addr = pc;
    assign State  = state;
    assign IR_Out = ir;
    assign Halted = (state == ST_HALT);
    assign Fault  = (state == ST_FAULT);

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised, multi-cycle instruction sequencer for the simple processor: program counter, instruction register and control FSM in one block, driving the register-file/ALU/data-memory datapath. It extends the fixed 16-bit controller with:
- width parameters;
- a request/valid fetch handshake to an external instruction memory;
- unconditional and zero-conditional jumps;
- a resumable halt;
- a sticky illegal-opcode fault.

## Interface
Parameters:
- PC_W, 7, program counter / instruction address width; PC_W <= 3*RF_AW
- RF_AW, 4, register-file address width; instruction width IR_W = 4 + 3*RF_AW (16 at default)
- D_AW, 8, data-memory address width; D_AW <= 2*RF_AW

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- I_Addr  out  PC_W  instruction address (= PC)
- I_Req  out  1  fetch request
- I_Valid  in  1  instruction memory returns I_Data this cycle
- I_Data  in  IR_W  fetched instruction
- Alu_Zero  in  1  datapath ALU zero flag
- Resume  in  1  leave HALT
- D_Addr  out  D_AW  data-memory address
- D_Wr  out  1  data-memory write enable
- RF_s  out  1  write-back mux select (1 = memory, 0 = ALU)
- RF_Ra_Addr, RF_Rb_Addr  out  RF_AW  register-file read addresses
- RF_W_en  out  1  register-file write enable
- RF_W_Addr  out  RF_AW  register-file write address
- ALU_s0  out  3  ALU function (000 pass/idle, 001 add, 010 sub)
- State  out  4  current FSM state encoding
- IR_Out  out  IR_W  instruction register
- Halted, Fault  out  1  status flags

## Operation
- Opcode field: IR[IR_W-1:IR_W-4].
  - Opcodes: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT, 6 JMP, 7 JZ; 8–15 illegal.
- Fields (R = RF_AW):
  - A = IR[3R-1:2R], B = IR[2R-1:R], W = IR[R-1:0].
  - LOAD: D_Addr = IR[R+D_AW-1:R], dest W.
  - STORE: source A, D_Addr = IR[D_AW-1:0].
  - ADD/SUB: W <= A op B.
  - JMP/JZ: target = IR[PC_W-1:0].
- States (encoding 0–10): INIT, FETCH, DECODE, LOAD_A, LOAD_B, STORE, ADD, SUB, JUMP, HALT, FAULT.
- State transitions and actions:
  - INIT: PC <= 0; go to FETCH.
  - FETCH: I_Req = 1. On I_Valid: IR <= I_Data, PC <= PC+1 (mod 2^PC_W), go to DECODE. Otherwise stay.
  - DECODE:
    - NOOP → FETCH; LOAD → LOAD_A; STORE → STORE; ADD → ADD; SUB → SUB; HALT → HALT; JMP → JUMP.
    - JZ → JUMP if Alu_Zero else FETCH.
    - Illegal → FAULT.
  - LOAD_A: D_Addr, RF_s = 1, RF_W_Addr driven; → LOAD_B.
  - LOAD_B: same outputs plus RF_W_en = 1; → FETCH.
  - STORE: D_Addr, RF_Ra_Addr = A, D_Wr = 1; → FETCH.
  - ADD / SUB: RF_Ra_Addr = A, RF_Rb_Addr = B, RF_W_Addr = W, RF_W_en = 1, RF_s = 0, ALU_s0 = 001 / 010; → FETCH.
  - JUMP: PC <= target; → FETCH.
  - HALT: Halted = 1; Resume → FETCH (PC already points past HALT).
  - FAULT: Fault = 1; stays in FAULT until Reset.
- Outputs are Moore-decoded from State and IR. Any address output not used in the current state is 0; strobes default to 0.

## Timing
- Reset values: State = INIT, PC = 0, IR = 0, every output 0.
- Reset is asynchronous and wins over every other input. Asserted mid-instruction, D_Wr, RF_W_en and I_Req deassert immediately, with no completion of the instruction.
- Fetch handshake:
  - I_Addr is stable while I_Req = 1.
  - I_Valid is ignored outside FETCH.
  - Zero-wait memory gives a 1-cycle FETCH.
- Cycles per instruction with zero-wait fetch, counting FETCH + DECODE + execute:
  - NOOP, HALT entry, JZ not taken: 2.
  - STORE, ADD, SUB, JMP, JZ taken: 3.
  - LOAD: 4.
- PC wraps from 2^PC_W−1 to 0 with no flag.
- Alu_Zero is sampled only in DECODE of a JZ.
- Resume is ignored outside HALT.

## Structure
- Shared package control_sequencer_pkg holds the opcode enum, the state enum (4-bit) and the ALU_s0 constants, shared with the datapath and the bench.
- One sub-module, pc_counter (clear / increment / load, parametrised by PC_W). The IR and FSM stay inline.

## Test plan
- Reset, then program {LOAD 0x1B→R2, LOAD 0x2A→R5, ADD R2+R5→R7, STORE R7→0x5C, HALT} with zero-wait memory.
  - Required: D_Addr 1B then 2A with RF_W_en in LOAD_B, ALU_s0 = 001 with W = 7, D_Wr = 1 at 5C, Halted = 1 after 17 cycles, I_Addr = 5.
- I_Valid delayed 3 cycles on every fetch: I_Req held, I_Addr stable, identical datapath sequence, each instruction 3 cycles longer.
- JMP 0x40 at address 2: next I_Addr = 0x40. JZ 0x10 with Alu_Zero = 0 → next I_Addr = PC+1; with Alu_Zero = 1 → I_Addr = 0x10.
- Opcode 0xF fetched: State = FAULT, Fault = 1, Resume ignored, Reset clears it.
- Reset asserted during STORE: D_Wr drops in the same cycle, State = INIT, PC = 0.
- PC_W = 4, PC at 15 fetches a NOOP: next I_Addr = 0. HALT followed by a Resume pulse continues the fetch at HALT address + 1.
